// File: rtl/multdiv_ctrl_if.sv
// Handshake bundle between the execute stage, the multdiv sequencer and the iterative multdiv unit.
interface multdiv_ctrl_if;
    logic        dx_is_mult;
    logic        dx_is_div;
    logic [31:0] dx_operandA;
    logic [31:0] dx_operandB;
    logic [4:0]  dx_rd;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_ready;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    modport master (
        output dx_is_mult, dx_is_div, dx_operandA, dx_operandB, dx_rd,
               md_result, md_exception, md_ready,
        input  ctrl_MULT, ctrl_DIV, md_operandA, md_operandB,
               stall, wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  dx_is_mult, dx_is_div, dx_operandA, dx_operandB, dx_rd,
               md_result, md_exception, md_ready,
        output ctrl_MULT, ctrl_DIV, md_operandA, md_operandB,
               stall, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/multdiv_ctrl.sv
// Sequences the shared iterative multiplier/divider: start pulse, pipeline stall,
// timeout supervision and a single writeback record per mul/div instruction.
module multdiv_ctrl #(
    parameter int unsigned TIMEOUT     = 40,
    parameter int unsigned CNT_W       = 6,
    parameter int unsigned RSTATUS_MUL = 4,
    parameter int unsigned RSTATUS_DIV = 5
) (
    input logic           i_clock,
    input logic           i_reset,
    multdiv_ctrl_if.slave io_md
);
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned STATUS_RD = 30;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_is_mul;
    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;
    logic [REG_W-1:0]    r_rd;
    logic [DATA_W-1:0]   r_result;
    logic                r_exc;
    logic                w_start;
    logic                w_timeout;
    logic                w_ctrl_mult;
    logic                w_ctrl_div;
    logic                w_stall;
    logic                w_wb_valid;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // Start decode is gated by reset so every output reads 0 while reset is held.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_timeout    = 1'b0;
        w_ctrl_mult  = 1'b0;
        w_ctrl_div   = 1'b0;
        w_stall      = 1'b0;
        w_wb_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_reset && (io_md.dx_is_mult || io_md.dx_is_div)) begin
                    w_start      = 1'b1;
                    w_ctrl_mult  = io_md.dx_is_mult;
                    w_ctrl_div   = !io_md.dx_is_mult;
                    w_stall      = 1'b1;
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                w_stall = 1'b1;
                if (io_md.md_ready) begin
                    w_next_state = S_DONE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_wb_valid   = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operand/result holding registers; a completed result always wins over a same-cycle timeout.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt    <= '0;
            r_is_mul <= 1'b0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_rd     <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else if (w_start) begin
            r_cnt    <= '0;
            r_is_mul <= io_md.dx_is_mult;
            r_op_a   <= io_md.dx_operandA;
            r_op_b   <= io_md.dx_operandB;
            r_rd     <= io_md.dx_rd;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (io_md.md_ready) begin
                r_result <= io_md.md_result;
                r_exc    <= io_md.md_exception;
            end else if (w_timeout) begin
                r_result <= '0;
                r_exc    <= 1'b1;
            end
        end
    end

    assign io_md.ctrl_MULT   = w_ctrl_mult;
    assign io_md.ctrl_DIV    = w_ctrl_div;
    assign io_md.stall       = w_stall;
    assign io_md.wb_valid    = w_wb_valid;
    assign io_md.md_operandA = r_op_a;
    assign io_md.md_operandB = r_op_b;

    always_comb begin
        io_md.wb_rd   = '0;
        io_md.wb_data = '0;
        if (w_wb_valid) begin
            if (r_exc) begin
                io_md.wb_rd   = REG_W'(STATUS_RD);
                io_md.wb_data = r_is_mul ? DATA_W'(RSTATUS_MUL) : DATA_W'(RSTATUS_DIV);
            end else begin
                io_md.wb_rd   = r_rd;
                io_md.wb_data = r_result;
            end
        end
    end
endmodule
